// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Freezes on I/D memory misses, inserts the load-use bubble, flushes on
// EX redirects, and keeps saturating performance counters.
module pipeline_hazard_controller #(
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_read,
  input  logic                  imem_resp,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic                  dmem_resp,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_redirect,
  output logic                  load_pc,
  output logic                  load_if_id,
  output logic                  load_id_ex,
  output logic                  load_ex_mem,
  output logic                  load_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [PERF_WIDTH-1:0] perf_mem_stall,
  output logic [PERF_WIDTH-1:0] perf_load_use,
  output logic [PERF_WIDTH-1:0] perf_redirect
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  logic [0:0]            r_state;
  logic                  r_i_done;
  logic                  r_d_done;
  logic [PERF_WIDTH-1:0] r_perf_mem_stall;
  logic [PERF_WIDTH-1:0] r_perf_load_use;
  logic [PERF_WIDTH-1:0] r_perf_redirect;

  logic w_i_pend;
  logic w_d_pend;
  logic w_ready;
  logic w_lu;
  logic w_flag_clear;

  assign w_i_pend = imem_read & ~r_i_done;
  assign w_d_pend = (dmem_read | dmem_write) & ~r_d_done;
  assign w_ready  = (~w_i_pend | imem_resp) & (~w_d_pend | dmem_resp);
  assign w_lu     = ex_is_load & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Done flags are only ever set on a stalled edge, which also enters
  // MEM_WAIT, so clearing on the MEM_WAIT exit covers every advance.
  assign w_flag_clear = w_ready & (r_state == S_MEM_WAIT);

  assign perf_mem_stall = r_perf_mem_stall;
  assign perf_load_use  = r_perf_load_use;
  assign perf_redirect  = r_perf_redirect;

  // Stage enables and flush controls from readiness and hazards.
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_ready) begin
      if (ex_redirect) begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (w_lu) begin
        load_id_ex  = 1'b1;
        flush_id_ex = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
    end
  end

  // RUN/MEM_WAIT sequencing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:      if (!w_ready) r_state <= S_MEM_WAIT;
        S_MEM_WAIT: if (w_ready)  r_state <= S_RUN;
        default:    r_state <= S_RUN;
      endcase
    end
  end

  // Sticky per-side response flags across a freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else if (w_flag_clear) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else if (!w_ready) begin
      if (imem_resp) r_i_done <= 1'b1;
      if (dmem_resp) r_d_done <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_mem_stall <= '0;
      r_perf_load_use  <= '0;
      r_perf_redirect  <= '0;
    end else if (!w_ready) begin
      if (r_perf_mem_stall != '1) r_perf_mem_stall <= r_perf_mem_stall + 1'b1;
    end else if (ex_redirect) begin
      if (r_perf_redirect != '1) r_perf_redirect <= r_perf_redirect + 1'b1;
    end else if (w_lu) begin
      if (r_perf_load_use != '1) r_perf_load_use <= r_perf_load_use + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus a random
// phase, all checked every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;

  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex;
  logic [31:0] perf_mem_stall, perf_load_use, perf_redirect;

  logic        b_load_pc, b_load_if_id, b_load_id_ex, b_load_ex_mem, b_load_mem_wb;
  logic        b_flush_if_id, b_flush_id_ex;
  logic [1:0]  b_perf_mem_stall, b_perf_load_use, b_perf_redirect;

  pipeline_hazard_controller u_dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .perf_mem_stall(perf_mem_stall), .perf_load_use(perf_load_use),
    .perf_redirect(perf_redirect)
  );

  pipeline_hazard_controller #(.PERF_WIDTH(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .load_pc(b_load_pc), .load_if_id(b_load_if_id), .load_id_ex(b_load_id_ex),
    .load_ex_mem(b_load_ex_mem), .load_mem_wb(b_load_mem_wb),
    .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex),
    .perf_mem_stall(b_perf_mem_stall), .perf_load_use(b_perf_load_use),
    .perf_redirect(b_perf_redirect)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: which side has already answered in this freeze,
  // and plain integer event counts clipped to the counter width.
  bit              m_i_sat = 1'b0, m_d_sat = 1'b0;
  longint unsigned m_stall = 0, m_lu = 0, m_redir = 0;
  longint unsigned m2_stall = 0, m2_lu = 0, m2_redir = 0;

  function automatic longint unsigned inc_sat(input longint unsigned v, input longint unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  logic [6:0] act_vec, act_vec2, exp_vec;
  assign act_vec  = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     flush_if_id, flush_id_ex};
  assign act_vec2 = {b_load_pc, b_load_if_id, b_load_id_ex, b_load_ex_mem, b_load_mem_wb,
                     b_flush_if_id, b_flush_id_ex};

  // Compare process: inputs change just after posedge, so negedge sees the
  // settled outputs for this cycle and the counters after the last edge.
  always @(negedge clk) begin
    bit waiting_i, waiting_d, ready, hz;
    chk("perf_mem_stall", perf_mem_stall, m_stall);
    chk("perf_load_use",  perf_load_use,  m_lu);
    chk("perf_redirect",  perf_redirect,  m_redir);
    chk("w2_perf_mem_stall", b_perf_mem_stall, m2_stall);
    chk("w2_perf_load_use",  b_perf_load_use,  m2_lu);
    chk("w2_perf_redirect",  b_perf_redirect,  m2_redir);
    if (!rst) begin
      exp_vec = 7'b0000011;
      m_i_sat = 0; m_d_sat = 0;
      m_stall = 0; m_lu = 0; m_redir = 0;
      m2_stall = 0; m2_lu = 0; m2_redir = 0;
    end else begin
      waiting_i = imem_read && !m_i_sat;
      waiting_d = (dmem_read || dmem_write) && !m_d_sat;
      ready = (!waiting_i || imem_resp) && (!waiting_d || dmem_resp);
      hz = ex_is_load && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (!ready)          exp_vec = 7'b0000000;
      else if (ex_redirect) exp_vec = 7'b1111111;
      else if (hz)          exp_vec = 7'b0011101;
      else                  exp_vec = 7'b1111100;
      if (!ready) begin
        m_stall  = inc_sat(m_stall, 64'hFFFF_FFFF);
        m2_stall = inc_sat(m2_stall, 3);
        if (imem_resp) m_i_sat = 1;
        if (dmem_resp) m_d_sat = 1;
      end else begin
        m_i_sat = 0; m_d_sat = 0;
        if (ex_redirect) begin
          m_redir = inc_sat(m_redir, 64'hFFFF_FFFF); m2_redir = inc_sat(m2_redir, 3);
        end else if (hz) begin
          m_lu = inc_sat(m_lu, 64'hFFFF_FFFF); m2_lu = inc_sat(m2_lu, 3);
        end
      end
    end
    chk("enables", act_vec, exp_vec);
    chk("w2_enables", act_vec2, exp_vec);
  end

  task automatic idle();
    imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
  endtask

  // Wait for this cycle's sample point (just past negedge).
  task automatic sample();
    @(negedge clk); #1;
  endtask

  // Advance to the next cycle's input-drive point (just past posedge).
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 0; sample(); next(); rst = 1;
  endtask

  initial begin
    rst = 0;
    idle();
    // Reset held with random inputs.
    for (int unsigned k = 0; k < 3; k++) begin
      {imem_read, imem_resp, dmem_read, dmem_write, dmem_resp} = 5'($urandom);
      {ex_is_load, ex_redirect, id_uses_rs1, id_uses_rs2} = 4'($urandom);
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_rd = 5'($urandom);
      sample();
      chk("rst_vec", act_vec, 7'b0000011);
      next();
    end
    chk("rst_perf", perf_mem_stall, 0);
    rst = 1; idle();
    sample();
    chk("post_rst_vec", act_vec, 7'b1111100);
    next();

    // Split response: D answers in cycle 2, I in cycle 5.
    imem_read = 1; dmem_read = 1;
    for (int unsigned c = 1; c <= 5; c++) begin
      dmem_resp = (c == 2);
      imem_resp = (c == 5);
      sample();
      if (c == 1 || c == 4) chk("split_frozen", act_vec, 7'b0000000);
      if (c == 5)           chk("split_adv", act_vec, 7'b1111100);
      next();
    end
    idle(); sample();
    chk("split_perf", perf_mem_stall, 4);
    next();

    // Load-use bubble on rs2.
    do_reset();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_uses_rs1 = 1; id_uses_rs2 = 1;
    sample(); chk("lu_bubble", act_vec, 7'b0011101); next();
    ex_is_load = 0;
    sample(); chk("lu_after", act_vec, 7'b1111100);
    chk("lu_perf", perf_load_use, 1); next();

    // No bubble: load to x0, and op_imm with matching but unread rs2.
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    sample(); chk("lu_x0", act_vec, 7'b1111100); next();
    ex_rd = 5; id_rs1 = 2; id_rs2 = 5; id_uses_rs1 = 1; id_uses_rs2 = 0;
    sample(); chk("lu_opimm", act_vec, 7'b1111100); next();

    // Redirect wins over load-use.
    do_reset();
    ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_redirect = 1;
    sample(); chk("redir_lu", act_vec, 7'b1111111); next();
    idle(); sample();
    chk("redir_perf", perf_redirect, 1);
    chk("redir_lu_perf", perf_load_use, 0); next();

    // Redirect held through a 3-cycle imem miss.
    do_reset();
    imem_read = 1; ex_redirect = 1;
    for (int unsigned c = 1; c <= 4; c++) begin
      imem_resp = (c == 4);
      sample();
      if (c <= 3) chk("redir_stall", act_vec, 7'b0000000);
      else        chk("redir_release", act_vec, 7'b1111111);
      next();
    end
    idle(); sample();
    chk("redir_stall_perf", perf_mem_stall, 3);
    chk("redir_stall_rcnt", perf_redirect, 1); next();

    // Five stall cycles: 2-bit counter sticks at 3.
    do_reset();
    imem_read = 1;
    for (int unsigned c = 1; c <= 6; c++) begin
      imem_resp = (c == 6);
      sample(); next();
    end
    idle(); sample();
    chk("sat_w32", perf_mem_stall, 5);
    chk("sat_w2", b_perf_mem_stall, 3); next();

    // Random phase, small register range for frequent matches.
    for (int unsigned k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 29) != 0);
      imem_read = ($urandom_range(0, 2) == 0);
      imem_resp = ($urandom_range(0, 2) == 0);
      dmem_read = ($urandom_range(0, 3) == 0);
      dmem_write = ($urandom_range(0, 5) == 0);
      dmem_resp = ($urandom_range(0, 2) == 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_is_load = 1'($urandom); ex_redirect = ($urandom_range(0, 4) == 0);
      sample(); next();
    end

    idle(); sample();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Issues per-stage register load enables and bubble/flush controls.
- Covers three cases: I-cache/D-cache miss freezes, the load-use bubble the forwarding path cannot cover (load result only forwardable from MEM/WB), and EX-resolved branch/jump redirects.
- Tracks split-response memory handshakes across the freeze and keeps saturating stall/flush performance counters.

Parameters:
- PERF_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_read  in  1  IF fetch request outstanding.
- imem_resp  in  1  I-side response this cycle.
- dmem_read  in  1  MEM-stage load request.
- dmem_write  in  1  MEM-stage store request.
- dmem_resp  in  1  D-side response this cycle.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2 (0 for lui/auipc/jal/jalr/load/op_imm).
- ex_is_load  in  1  EX instruction opcode is op_load.
- ex_rd  in  5  EX destination register.
- ex_redirect  in  1  EX branch taken, or jal/jalr; PC must take the EX target.
- load_pc  out  1  PC register enable.
- load_if_id  out  1  IF/ID enable.
- load_id_ex  out  1  ID/EX enable.
- load_ex_mem  out  1  EX/MEM enable.
- load_mem_wb  out  1  MEM/WB enable.
- flush_if_id  out  1  IF/ID loads a NOP (valid only with load_if_id).
- flush_id_ex  out  1  ID/EX loads a NOP control word (valid only with load_id_ex).
- perf_mem_stall  out  PERF_WIDTH  cycles frozen on memory.
- perf_load_use  out  PERF_WIDTH  load-use bubbles inserted.
- perf_redirect  out  PERF_WIDTH  redirects taken.

Behaviour:
- State: FSM {RUN, MEM_WAIT}, plus sticky flags i_done and d_done, plus the three counters.
- Reset (rst=0 at an edge): state=RUN, flags=0, counters=0.
- While rst=0, outputs are combinationally forced: all load_*=0, flush_if_id=1, flush_id_ex=1.
- Request pending:
  - i_pend = imem_read & ~i_done.
  - d_pend = (dmem_read | dmem_write) & ~d_done.
- ready = (~i_pend | imem_resp) & (~d_pend | dmem_resp). A response in the same cycle counts.
- advance = ready. When advance=0, every load_* = 0 and flush_*=0; the whole pipeline freezes.
- Flag updates:
  - A response arriving while ready=0 sets the matching done flag, so the satisfied side is not waited on again.
  - Both flags clear on any advance cycle.
- FSM transitions:
  - RUN -> MEM_WAIT when ready=0.
  - MEM_WAIT -> RUN on the cycle ready=1; that cycle is itself an advance cycle.
  - MEM_WAIT holds otherwise.
  - State affects only the counters/flags; the enables are functions of ready and hazards.
- Load-use hazard: lu = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Redirect priority is above load-use: the ID instruction is wrong-path.
- On an advance cycle:
  - ex_redirect=1: all load_*=1, flush_if_id=1, flush_id_ex=1.
  - else lu=1: load_pc=0, load_if_id=0, load_id_ex=1 with flush_id_ex=1, load_ex_mem=1, load_mem_wb=1, flush_if_id=0. Exactly one bubble; the next cycle lu is 0 because the load has moved to MEM.
  - else: all load_*=1, flushes=0.
- Redirect under stall: ex_redirect is held by the frozen EX stage and takes effect on the first advance cycle. A wrong-path imem fetch still outstanding is waited for, then discarded via flush_if_id.
- Counters (saturate at all-ones, never wrap):
  - perf_mem_stall +1 for each cycle with rst=1 & ready=0.
  - perf_load_use +1 for each advance cycle with lu & ~ex_redirect.
  - perf_redirect +1 for each advance cycle with ex_redirect.
- Reset mid-stall: flags, state and counters clear at the next edge. No pending response is remembered.
- Latency: enables are combinational, zero cycle. Flags, state and counters are updated at the edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all load_*=0, flush_*=1, counters 0; after release with no requests pending -> all load_*=1.
- Split response: imem_read=1 and dmem_read=1; dmem_resp in cycle 2, imem_resp in cycle 5 (dmem_read held) -> loads 0 in cycles 1-4, all 1 in cycle 5; perf_mem_stall=4; no second dmem wait.
- Load-use: EX = lw x5 (ex_rd=5), ID = add using rs2=5 -> one cycle with load_pc=0, load_if_id=0, flush_id_ex=1; next cycle, with ex_is_load=0, normal advance; perf_load_use=1.
- Load-use to x0, or to a non-read operand (op_imm, rs2 matching) -> no bubble.
- Redirect plus load-use together: ex_redirect=1 and lu=1 -> all loads 1, both flushes 1; perf_redirect=1, perf_load_use=0.
- Redirect during an imem miss lasting 3 cycles -> loads 0 for 3 cycles, then a single advance with both flushes. Set PERF_WIDTH=2 and force 5 stall cycles -> perf_mem_stall saturates at 3.
